therm_accum7: RTL
=================

# therm_accum7

Frame accumulator placed directly downstream of the single-stage 7-input 1-bit sorter. Each cycle it accepts one sorted 7-bit word, where the ones are packed at the MSB end. It decodes the word to a 0..7 count, checks that the code is monotone, and sums counts over a frame of up to FRAME_LEN words. Each completed frame is presented as one result on a valid/ready output port.

## Interface
- FRAME_LEN, 16: words per frame, ≥1; a frame also ends early on in_last
- ACC_W, 8: out_sum width; must satisfy 2^ACC_W > 7*FRAME_LEN
- WORD_W, $clog2(FRAME_LEN+1): out_words width (derived)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_therm/in_last valid
- in_ready  out  1  block accepts input this cycle
- in_therm  in  7  sorter output; valid code is ones packed at bit 6 downward
- in_last  in  1  word closes the current frame
- out_valid  out  1  frame result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  ACC_W  sum of word counts in frame
- out_words  out  WORD_W  words in frame (1..FRAME_LEN)
- out_err  out  1  at least one non-monotone word in frame

## Operation
- Input transfer happens on in_valid && in_ready. out_valid/out_* hold stable until out_ready; upstream must hold its data while stalled.
- Decode stage (S1 register, fields d_valid/d_cnt/d_err/d_last):
  - d_cnt = popcount(in_therm), 3 bits.
  - d_err = 1 iff there exists k<6 with in_therm[k]=1 and in_therm[k+1]=0. Valid codes: 0x00, 0x40, 0x60, 0x70, 0x78, 0x7C, 0x7E, 0x7F.
  - A non-monotone word still contributes its popcount.
- Accumulator FSM:
  - ACC:
    - If d_valid: acc += d_cnt; words += 1; err |= d_err; S1 entry consumed.
    - If d_last, or the word is number FRAME_LEN: load out_sum/out_words/out_err from the updated values, clear acc/words/err, set out_valid, go to FULL.
  - FULL:
    - S1 does not drain; out_valid stays 1.
    - On out_ready: out_valid drops next cycle, go to ACC.
- in_ready = !d_valid || state==ACC. S1 loads a new word in the same cycle it is consumed.
- Arithmetic: acc is ACC_W bits and never overflows under the parameter rule. words is WORD_W bits. Both are zero-extended adds.

## Timing
- Reset values: out_valid=0, out_sum=0, out_words=0, out_err=0, in_ready=1, d_valid=0, state ACC, acc/words/err=0.
- Latency: word accepted at edge t is decoded into S1 at t. It is accumulated at t+1. If that word closes the frame, out_valid=1 in the cycle after t+1.
- Throughput: 1 word/cycle in ACC. At least one stall cycle per frame, because S1 is held while in FULL. A FULL with out_ready already high lasts exactly one cycle.
- FRAME_LEN=1: every word is its own frame.
- in_last arriving together with word count FRAME_LEN produces one frame, not two.
- Reset mid-frame or while FULL: the partial or pending frame is discarded, S1 is flushed, and nothing is emitted.
- in_valid while FULL with d_valid=1: not accepted (in_ready=0); upstream holds.

## Structure
- Package therm_pkg:
  - SORT_N=7, CNT_W=3.
  - Function therm_monotone(logic [6:0]) returning the monotone-code check.
  - FSM enum {ACC, FULL}.
- Sub-module therm7_decode: combinational; in_therm → cnt[2:0], err. Instanced once, feeding the S1 register.

## Test plan
- Reset then 16 words of 0x7F, in_last=0, out_ready=1 → one result: out_sum=112, out_words=16, out_err=0, out_valid high for one cycle.
- Words 0x40, 0x60, 0x70 with in_last on the third word → out_sum=6, out_words=3, out_err=0. Output appears 2 cycles after the third word is accepted.
- Frame containing 0x05 (non-monotone) plus 15×0x00 → out_sum=2, out_words=16, out_err=1. The next frame of all-valid words reports out_err=0.
- Hold out_ready=0 for 5 cycles after out_valid while in_valid stays 1:
  - in_ready stays 0 once S1 is full.
  - out_* stay stable.
  - After the handshake, the next frame sums correctly with no lost or duplicated word.
- Assert rst for one cycle after 7 words of 0x7E → all outputs return to reset values. The following frame of 16×0x40 yields out_sum=16, out_words=16.
- Random in_valid/out_ready backpressure over 1000 sorted words from a reference popcount model → frame sums and word counts match exactly.

Source files
------------

// File: rtl/therm_pkg.sv
// therm_pkg: shared widths, FSM states and monotone-code check for the 7-input thermometer accumulator
package therm_pkg;
  localparam int SORT_N = 7;
  localparam int CNT_W = 3;
  typedef enum logic {ACC, FULL} state_t;
  function automatic logic therm_monotone(input logic [SORT_N-1:0] t);
    return ((t & ~(t >> 1)) & 7'h3f) == '0;
  endfunction
endpackage

// File: rtl/therm7_decode.sv
// therm7_decode: sorted 7-bit word to 0..7 count plus non-monotone flag
module therm7_decode
  import therm_pkg::*;
(
  input  logic [SORT_N-1:0] therm,
  output logic [CNT_W-1:0]  cnt,
  output logic              err
);
  assign cnt = CNT_W'($countones(therm));
  assign err = !therm_monotone(therm);
endmodule

// File: rtl/therm_accum7.sv
// therm_accum7: decodes sorted words and sums their counts per frame onto a valid/ready result port
module therm_accum7
  import therm_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int ACC_W = 8,
  parameter int WORD_W = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SORT_N-1:0] in_therm,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [WORD_W-1:0] out_words,
  output logic              out_err
);
  state_t state, state_n;
  logic d_valid, d_err, d_last, dec_err, err, accept, consume, close;
  logic [CNT_W-1:0] d_cnt, dec_cnt;
  logic [ACC_W-1:0] acc, acc_n;
  logic [WORD_W-1:0] words, words_n;
  therm7_decode u_dec (.therm(in_therm), .cnt(dec_cnt), .err(dec_err));
  assign in_ready = !d_valid || state == ACC;
  assign accept = in_valid && in_ready;
  assign consume = state == ACC && d_valid;
  assign acc_n = acc + ACC_W'(d_cnt);
  assign words_n = words + WORD_W'(1);
  assign close = consume && (d_last || words_n == WORD_W'(FRAME_LEN));
  always_comb begin
    state_n = state;
    state_n = (state == ACC) ? (close ? FULL : ACC) : (out_ready ? ACC : FULL);
  end
  always_ff @(posedge clk)
    if (rst) state <= ACC;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      d_valid <= 1'b0;
      d_cnt <= '0;
      d_err <= 1'b0;
      d_last <= 1'b0;
      acc <= '0;
      words <= '0;
      err <= 1'b0;
      out_valid <= 1'b0;
      out_sum <= '0;
      out_words <= '0;
      out_err <= 1'b0;
    end else begin
      if (accept) begin
        d_valid <= 1'b1;
        d_cnt <= dec_cnt;
        d_err <= dec_err;
        d_last <= in_last;
      end else if (consume) d_valid <= 1'b0;
      if (consume) begin
        acc <= close ? '0 : acc_n;
        words <= close ? '0 : words_n;
        err <= close ? 1'b0 : err | d_err;
      end
      if (close) begin
        out_valid <= 1'b1;
        out_sum <= acc_n;
        out_words <= words_n;
        out_err <= err | d_err;
      end else if (state == FULL && out_ready) out_valid <= 1'b0;
    end
  end
endmodule
